// File: rtl/alu_mul_seq.sv
// Sequential 16x16 unsigned shift-add multiplier that uses the shared ALU for every add.
// Optional MUL_ZERO_BYPASS_EN: a zero operand finishes in one cycle without ALU use.
module alu_mul_seq #(
  parameter logic [3:0] OP_ADD = 4'b1000,
  parameter logic [3:0] OP_SCO = 4'b1100,
  parameter int         NBITS  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NBITS-1:0] a,
  input  logic [NBITS-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [NBITS-1:0] prod_hi,
  output logic [NBITS-1:0] prod_lo,
  output logic [NBITS-1:0] alu_A,
  output logic [NBITS-1:0] alu_B,
  output logic [3:0]       alu_Op,
  output logic             alu_Cin,
  output logic             alu_invA,
  output logic             alu_invB,
  output logic             alu_sign,
  input  logic [NBITS-1:0] alu_Out
);

  localparam int CNT_W = $clog2(NBITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADD   = 2'd1;
  localparam logic [1:0] S_CARRY = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q,   state_d;
  logic [NBITS-1:0] mcand_q,   mcand_d;
  logic [NBITS-1:0] mplr_q,    mplr_d;
  logic [NBITS-1:0] acc_hi_q,  acc_hi_d;
  logic [NBITS-1:0] sum_q,     sum_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [NBITS-1:0] prod_hi_q, prod_hi_d;
  logic [NBITS-1:0] prod_lo_q, prod_lo_d;

  logic             shift_s;
  logic             sh_top_s;
  logic [NBITS-1:0] sh_src_s;
  logic [NBITS-1:0] alu_a_s;
  logic [NBITS-1:0] alu_b_s;
  logic [3:0]       alu_op_s;

  // Next-state, ALU drive and shift/accumulate decode
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_hi_d  = acc_hi_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    prod_hi_d = prod_hi_q;
    prod_lo_d = prod_lo_q;
    shift_s   = 1'b0;
    sh_top_s  = 1'b0;
    sh_src_s  = acc_hi_q;
    alu_a_s   = '0;
    alu_b_s   = '0;
    alu_op_s  = OP_ADD;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d  = a;
          mplr_d   = b;
          acc_hi_d = '0;
          cnt_d    = '0;
`ifdef MUL_ZERO_BYPASS_EN
          if ((a == '0) || (b == '0)) begin
            prod_hi_d = '0;
            prod_lo_d = '0;
            state_d   = S_DONE;
          end else begin
            state_d = S_ADD;
          end
`else
          state_d = S_ADD;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADD: begin
        if (mplr_q[0]) begin
          alu_a_s = acc_hi_q;
          alu_b_s = mcand_q;
          alu_op_s = OP_ADD;
          sum_d   = alu_Out;
          state_d = S_CARRY;
        end else begin
          shift_s  = 1'b1;
          sh_top_s = 1'b0;
          sh_src_s = acc_hi_q;
        end
      end
      S_CARRY: begin
        // Same operands again; SCO returns the carry the ADD cycle lost
        alu_a_s  = acc_hi_q;
        alu_b_s  = mcand_q;
        alu_op_s = OP_SCO;
        shift_s  = 1'b1;
        sh_top_s = alu_Out[0];
        sh_src_s = sum_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (shift_s) begin
      acc_hi_d = {sh_top_s, sh_src_s[NBITS-1:1]};
      mplr_d   = {sh_src_s[0], mplr_q[NBITS-1:1]};
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LAST) begin
        prod_hi_d = acc_hi_d;
        prod_lo_d = mplr_d;
        state_d   = S_DONE;
      end else begin
        state_d = S_ADD;
      end
    end else begin
      cnt_d = cnt_d;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_hi_q  <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      prod_hi_q <= '0;
      prod_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_hi_q  <= acc_hi_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      prod_hi_q <= prod_hi_d;
      prod_lo_q <= prod_lo_d;
    end
  end

  assign busy     = (state_q == S_ADD) || (state_q == S_CARRY);
  assign done     = (state_q == S_DONE);
  assign prod_hi  = prod_hi_q;
  assign prod_lo  = prod_lo_q;
  assign alu_A    = alu_a_s;
  assign alu_B    = alu_b_s;
  assign alu_Op   = alu_op_s;
  assign alu_Cin  = 1'b0;
  assign alu_invA = 1'b0;
  assign alu_invB = 1'b0;
  assign alu_sign = 1'b0;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural ALU and an expected-result queue.
module tb_alu_mul_seq;

  localparam logic [3:0] OP_ADD = 4'b1000;
  localparam logic [3:0] OP_SCO = 4'b1100;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] prod_hi;
  logic [15:0] prod_lo;
  logic [15:0] alu_A;
  logic [15:0] alu_B;
  logic [3:0]  alu_Op;
  logic        alu_Cin;
  logic        alu_invA;
  logic        alu_invB;
  logic        alu_sign;
  logic [15:0] alu_Out;
  logic [16:0] alu_sum;

  typedef struct {
    logic [31:0] prod;
    int          lat;
    int          sco;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_mul_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .prod_hi  (prod_hi),
    .prod_lo  (prod_lo),
    .alu_A    (alu_A),
    .alu_B    (alu_B),
    .alu_Op   (alu_Op),
    .alu_Cin  (alu_Cin),
    .alu_invA (alu_invA),
    .alu_invB (alu_invB),
    .alu_sign (alu_sign),
    .alu_Out  (alu_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: only ADD and SCO are meaningful to this block
  always_comb begin
    alu_sum = {1'b0, alu_A} + {1'b0, alu_B} + {16'h0000, alu_Cin};
    case (alu_Op)
      OP_ADD:  alu_Out = alu_sum[15:0];
      OP_SCO:  alu_Out = {15'h0000, alu_sum[16]};
      default: alu_Out = 16'hDEAD;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [15:0] av, input logic [15:0] bv, input bit push);
    exp_t e;
    bit   zero;
    zero = 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
    zero = (av == 16'h0000) || (bv == 16'h0000);
`endif
    a     = av;
    b     = bv;
    start = 1'b1;
    if (push) begin
      e.prod = {16'h0000, av} * {16'h0000, bv};
      e.lat  = zero ? 1 : 17 + $countones(bv);
      e.sco  = zero ? 0 : $countones(bv);
      sb_q.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  // Called right after issue(); counts cycles to done, optionally pokes start mid-run
  task automatic wait_done(input int inject);
    exp_t e;
    int   n;
    int   busy_n;
    int   sco_n;
    n      = 1;
    busy_n = 0;
    sco_n  = 0;
    while ((done !== 1'b1) && (n < 200)) begin
      if (busy === 1'b1) busy_n++;
      if (alu_Op === OP_SCO) sco_n++;
      if (n == inject) begin
        a     = 16'd1;
        b     = 16'd1;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      n++;
    end
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      check("latency", 32'(n), 32'(e.lat));
      check("busy_cycles", 32'(busy_n), 32'(e.lat - 1));
      check("sco_count", 32'(sco_n), 32'(e.sco));
      check("done", {31'h0, done}, 32'h1);
      check("product", {prod_hi, prod_lo}, e.prod);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 16'h0000;
    b     = 16'h0000;
    tick();
    tick();
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_prod", {prod_hi, prod_lo}, 32'h0);
    check("rst_alu_op", {28'h0, alu_Op}, {28'h0, OP_ADD});
    check("rst_alu_ab", {alu_A, alu_B}, 32'h0);
    check("rst_alu_const", {28'h0, alu_Cin, alu_invA, alu_invB, alu_sign}, 32'h0);
    rst_n = 1'b1;
    tick();

    issue(16'd3, 16'd5, 1'b1);
    wait_done(0);

    issue(16'hFFFF, 16'hFFFF, 1'b1);
    wait_done(0);

    issue(16'h1234, 16'h0000, 1'b1);
    wait_done(0);

    issue(16'd7, 16'd9, 1'b1);
    wait_done(3);
    tick();
    check("done_pulse_width", {31'h0, done}, 32'h0);
    tick();
    tick();
    tick();
    check("prod_held", {prod_hi, prod_lo}, 32'h0000_003F);
    check("idle_alu_op", {28'h0, alu_Op}, {28'h0, OP_ADD});
    check("idle_alu_ab", {alu_A, alu_B}, 32'h0);

    // Abort in the 5th busy cycle
    issue(16'h1234, 16'h5678, 1'b0);
    tick();
    tick();
    tick();
    tick();
    check("pre_abort_busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_prod", {prod_hi, prod_lo}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    issue(16'd2, 16'h8000, 1'b1);
    wait_done(0);

    issue(16'd3, 16'd5, 1'b1);
    wait_done(0);
    issue(16'h0010, 16'h0010, 1'b1);
    wait_done(0);

    tick();
    check("sb_empty", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle 16x16 unsigned multiply sequencer that borrows the shared 16-bit ALU instead of owning an adder.
- Each partial-product add is issued as an ALU ADD op (4'b1000), and its carry-out is recovered with a follow-up ALU SCO op (4'b1100).
- The 32-bit accumulator, multiplier shift register and bit counter live in this block.
- Sits beside the ALU in the execute stage; the stall logic holds the pipeline while busy is high.

Parameters:
- OP_ADD, 4'b1000, ALU opcode that returns A+B+Cin.
- OP_SCO, 4'b1100, ALU opcode that returns {15'b0, carry-out of A+B+Cin}.
- NBITS, 16, operand width and iteration count; only 16 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; a and b are sampled when start=1 and state is IDLE or DONE.
- a  in  16  multiplicand.
- b  in  16  multiplier.
- busy  out  1  high in the ADD and CARRY states.
- done  out  1  one-cycle pulse when the product is valid.
- prod_hi  out  16  product bits 31:16; held until the next accepted start.
- prod_lo  out  16  product bits 15:0; held until the next accepted start.
- alu_A  out  16  ALU A operand.
- alu_B  out  16  ALU B operand.
- alu_Op  out  4  ALU opcode.
- alu_Cin  out  1  ALU carry-in; constant 0.
- alu_invA  out  1  constant 0.
- alu_invB  out  1  constant 0.
- alu_sign  out  1  constant 0.
- alu_Out  in  16  ALU result; combinational, valid in the same cycle.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0; done=0.
  - prod_hi, prod_lo, accumulator, multiplier register and counter all cleared to 0.
  - alu_A=0, alu_B=0, alu_Op=OP_ADD.
- States: IDLE, ADD, CARRY, DONE.
- IDLE/DONE with start=1:
  - mcand<=a; mplr<=b; acc_hi<=0; cnt<=0.
  - Next state is ADD.
- ADD, mplr[0]=1:
  - Drive alu_A=acc_hi, alu_B=mcand, alu_Op=OP_ADD.
  - Latch alu_Out into sum_r.
  - Next state is CARRY.
- ADD, mplr[0]=0:
  - No ALU use; alu_A=alu_B=0.
  - Shift: {acc_hi, mplr} <= {1'b0, acc_hi, mplr} >> 1; cnt++.
- CARRY:
  - Drive the same operands with alu_Op=OP_SCO; c=alu_Out[0].
  - Shift: {acc_hi, mplr} <= {c, sum_r, mplr} >> 1; cnt++.
  - Next state is ADD.
- After the 16th shift (cnt reaches 15 and increments):
  - prod_hi<=acc_hi, prod_lo<=mplr, both taken from the post-shift values.
  - Next state is DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Go to IDLE, or back to ADD if start=1 (back-to-back operation allowed).
- Latency: start accepted in cycle 0; ADD/CARRY occupy 16+popcount(b) cycles; done is high in the cycle after the last shift.
- start while busy: ignored; operands and progress are unaffected.
- ALU port values outside the ADD/CARRY ALU-use cycles: alu_A=alu_B=0, alu_Op=OP_ADD.
- prod_* are not updated during an operation; they change only at completion.
- Reset mid-operation: aborts immediately to the reset values; no done pulse is produced.
- Arithmetic is unsigned only; the product cannot overflow 32 bits.

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- Defined: when start is accepted with a==0 or b==0, go directly to DONE in the next cycle with prod_hi=prod_lo=0. No ADD/CARRY cycles occur and busy stays 0.
- Undefined: zero operands take the normal 16+popcount(b) cycles and still produce 0.

Test Plan:
- a=3, b=5 -> done 19 cycles after start (16+2 busy cycles, then done); prod_hi=0x0000, prod_lo=0x000F; alu_Op=4'b1100 seen exactly 2 times.
- a=0xFFFF, b=0xFFFF -> prod_hi=0xFFFE, prod_lo=0x0001 after 32 busy cycles; exercises the carry path via SCO.
- a=0x1234, b=0 -> prod=0; 16 busy cycles without the macro; with MUL_ZERO_BYPASS_EN, done in the cycle after start and busy never asserted.
- a=7, b=9 with start pulsed again mid-operation (a=1, b=1) -> the second start is ignored; result is 0x0000_003F; prod held after done until the next start.
- rst_n=0 in the 5th busy cycle -> busy=0, done=0, prod=0 asynchronously; new start a=2, b=0x8000 -> prod_hi=0x0001, prod_lo=0x0000.
- done in the same cycle as start (a=0x0010, b=0x0010) -> back-to-back accepted, no idle cycle; prod=0x0000_0100.
